hc4_prog_loader: RTL

//  Serial program loader for the HC4 core: receives an 8N1 UART frame, writes the payload bytes into
//  the 4096x8 instruction ROM write port from address 0 upward, and holds the core in reset during a load.

---
 rtl/hc4_prog_loader_pkg.sv | 41 ++++
 rtl/hc4_prog_loader_uart_rx.sv | 108 ++++++++++
 rtl/hc4_prog_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hc4_prog_loader_pkg.sv
// ============================================================================
// Module      : hc4_prog_loader_pkg
// Description : Shared widths, frame marker and state encodings for the HC4
//               serial program loader and its UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hc4_prog_loader_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 8;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Loader frame FSM
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN_H = 3'd1,
        ST_LEN_L = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } ld_state_t;

    // UART receiver FSM
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A frame is in progress from the length header up to the checksum byte
    function automatic logic is_busy(input ld_state_t s);
        return (s == ST_LEN_H) || (s == ST_LEN_L) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hc4_prog_loader_uart_rx.sv
// ============================================================================
// Module      : hc4_prog_loader_uart_rx
// Description : 8N1 UART receiver. Two-stage synchroniser, falling-edge start
//               detect, mid-bit sampling, one-cycle byte / framing strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc4_prog_loader_uart_rx
    import hc4_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Start edge is seen one clock late through the edge detector, so the
    // half-bit point is reached MID counts after entering RX_START.
    localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Synchronise rx and keep its previous value for falling-edge detection
    always_ff @(posedge clk) begin
        if (Reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Bit-timing state machine producing registered byte and error strobes
    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s2) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == MID) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A line already high again at mid-bit was only a glitch
                        state   <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hc4_prog_loader.sv
// ============================================================================
// Module      : hc4_prog_loader
// Description : Serial program loader. Receives SYNC/LEN_H/LEN_L/payload/CHK
//               frames over UART, writes payload into the instruction ROM and
//               holds the core in reset while a load is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc4_prog_loader
    import hc4_prog_loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         TIMEOUT_CLKS = 40960,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  rx,
    output logic                  rom_we,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [ROM_DATA_W-1:0] rom_wdata,
    output logic                  cpu_nReset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_frame_err;
    ld_state_t             state;
    logic [ROM_ADDR_W-1:0] len;       // payload length minus one
    logic [ROM_ADDR_W-1:0] addr_cnt;
    logic [7:0]            chk_sum;
    logic [TO_W-1:0]       to_cnt;
    logic                  rst_d;     // high in the first cycle after Reset
    logic                  abort;

    hc4_prog_loader_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk          (clk),
        .Reset        (Reset),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    assign busy  = is_busy(state);
    assign done  = (state == ST_DONE);
    assign abort = busy && (rx_frame_err || (to_cnt >= TO_W'(TIMEOUT_CLKS)));

    // Frame FSM with address counter, checksum, inter-byte timeout and core reset control
    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            len        <= '0;
            addr_cnt   <= '0;
            chk_sum    <= '0;
            to_cnt     <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            cpu_nReset <= 1'b0;
            error      <= 1'b0;
            rst_d      <= 1'b1;
        end else begin
            rom_we <= 1'b0;
            rst_d  <= 1'b0;
            if (rst_d) cpu_nReset <= 1'b1;

            if (busy && !rx_valid) to_cnt <= to_cnt + 1'b1;
            else                   to_cnt <= '0;

            if (abort) begin
                state <= ST_ERR;
                error <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state      <= ST_LEN_H;
                            chk_sum    <= '0;
                            error      <= 1'b0;
                            cpu_nReset <= 1'b0;
                        end
                    end
                    ST_LEN_H: begin
                        if (rx_valid) begin
                            if (rx_data[7:4] != 4'h0) begin
                                state <= ST_ERR;
                                error <= 1'b1;
                            end else begin
                                len[11:8] <= rx_data[3:0];
                                state     <= ST_LEN_L;
                            end
                        end
                    end
                    ST_LEN_L: begin
                        if (rx_valid) begin
                            len[7:0] <= rx_data;
                            addr_cnt <= '0;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (rx_valid) begin
                            rom_we    <= 1'b1;
                            rom_addr  <= addr_cnt;
                            rom_wdata <= rx_data;
                            chk_sum   <= chk_sum + rx_data;
                            // Last byte stops the counter so a full 4096-byte load never wraps
                            if (addr_cnt == len) state <= ST_CHK;
                            else                 addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                    ST_CHK: begin
                        if (rx_valid) begin
                            if (8'(chk_sum + rx_data) == 8'h00) begin
                                state <= ST_DONE;
                            end else begin
                                state <= ST_ERR;
                                error <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        cpu_nReset <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    ST_ERR:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
